// File: rtl/sync_fifo_status.sv
// Show-ahead synchronous FIFO with occupancy count, runtime almost-full/empty thresholds and flush.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_status #(
  parameter int DATA_BIT = 8,
  parameter int W        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr,
  input  logic [DATA_BIT-1:0] w_data,
  input  logic                rd,
  output logic [DATA_BIT-1:0] r_data,
  input  logic [W:0]          af_thresh,
  input  logic [W:0]          ae_thresh,
  output logic [W:0]          count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam logic [W:0] DEPTH = (W+1)'(2**W);

  logic [DATA_BIT-1:0] mem [2**W];

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         af_q, af_d;
  logic         ae_q, ae_d;
  logic         init_q, init_d;
  logic         rd_en, wr_en;

  always_comb begin
    rd_en   = rd & ~empty_q;
    wr_en   = wr & (~full_q | rd_en);
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    init_d  = 1'b0;
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_en) w_ptr_d = w_ptr_q + W'(1);
      if (rd_en) r_ptr_d = r_ptr_q + W'(1);
      if (wr_en && !rd_en)      count_d = count_q + (W+1)'(1);
      else if (rd_en && !wr_en) count_d = count_q - (W+1)'(1);
    end
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
    af_d    = (count_d >= af_thresh);
    ae_d    = (count_d <= ae_thresh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      init_q  <= 1'b1;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      init_q  <= init_d;
    end
  end

  // Storage is deliberately left unreset; a flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[w_ptr_q] <= w_data;
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr & ~wr_en);
    underflow_d = underflow_q | (rd & ~rd_en);
    if (clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  // Until the first edge after reset, almost_full must track the live threshold against an empty FIFO.
  assign almost_full  = init_q ? (af_thresh == '0) : af_q;
  assign almost_empty = ae_q;
  assign r_data       = mem[r_ptr_q];
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;

endmodule

// File: doc/sync_fifo_status.md
# sync_fifo_status

Parametrised synchronous single-clock FIFO, the next generation of the switching module's packet-buffer FIFO. Adds an occupancy count, runtime almost-full/almost-empty thresholds, a synchronous flush and defined full/empty behaviour under simultaneous read and write. It sits between the port ingress logic and the shared-cache write arbiter, and at every per-port egress queue.

## Interface
- DATA_BIT, 8, data word width in bits
- W, 4, address width; depth = 2**W entries (W >= 1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush
- wr  in  1  write request
- w_data  in  DATA_BIT  write data
- rd  in  1  read request (pop)
- r_data  out  DATA_BIT  head-of-queue data (show-ahead)
- af_thresh  in  W+1  almost-full level
- ae_thresh  in  W+1  almost-empty level
- count  out  W+1  occupancy, 0..2**W
- full  out  1  count == 2**W
- empty  out  1  count == 0
- almost_full  out  1  count >= af_thresh
- almost_empty  out  1  count <= ae_thresh
- overflow  out  1  sticky; present only with SYNC_FIFO_ERR_EN
- underflow  out  1  sticky; present only with SYNC_FIFO_ERR_EN

## Operation
- Acceptance:
  - rd_en = rd & ~empty.
  - wr_en = wr & (~full | rd_en).
  - At full, a simultaneous rd and wr accepts both.
  - At empty, a simultaneous rd and wr accepts only the write.
- Storage: 2**W x DATA_BIT register array, not reset. Write at w_ptr; r_data = mem[r_ptr] combinationally. r_data is meaningful only while empty = 0.
- Pointers are W bits and wrap modulo 2**W. Each advances by 1 on its enable.
- count_next:
  - count + 1 on wr_en only.
  - count - 1 on rd_en only.
  - Unchanged when both or neither are enabled.
- full, empty, almost_full and almost_empty are registered, computed from count_next and the current thresholds.
- Threshold values above 2**W are legal:
  - almost_full never asserts.
  - almost_empty always asserts.
- clr has priority over rd and wr in the same cycle. It has the same effect as reset except that memory is untouched.
- Reset values: count = 0, empty = 1, full = 0, almost_full = (af_thresh == 0), almost_empty = 1, overflow = 0, underflow = 0, both pointers = 0.
- Reset takes effect immediately at any time, including mid-burst. In-flight data is lost.

## Timing
- Write accepted at edge n:
  - Data is readable on r_data and empty deasserts after edge n.
  - count reflects the write after edge n.
- Read latency is 0: r_data shows the head before the rd edge. After a rd_en edge, r_data shows the next entry in the same cycle that count updates.
- All flags update on the same edge as count. There is no flag lag relative to count.
- A threshold change takes effect on the next edge.
- Sustained throughput is one write and one read per cycle at any occupancy except empty (write only).

## Configuration
- Macro: SYNC_FIFO_ERR_EN.
- Defined:
  - overflow sets on any cycle with wr & ~wr_en.
  - underflow sets on any cycle with rd & ~rd_en.
  - Both are sticky until clr or rst_n.
- Undefined: both ports and their logic are absent. Dropped requests are silently ignored.

## Test plan
- Reset, W=2, af_thresh=3, ae_thresh=1 -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, all held across 5 idle cycles.
- Write 0x11, 0x22, 0x33, 0x44, then 0x55:
  - After the 3rd write, almost_full=1.
  - After the 4th write, full=1 and count=4.
  - 0x55 is dropped and overflow=1.
  - Four reads return 0x11, 0x22, 0x33, 0x44; then empty=1.
- Full with 0x11..0x44, then rd&wr with 0x66 for 1 cycle -> count stays 4, full stays 1, r_data=0x22; subsequent drain yields 0x22, 0x33, 0x44, 0x66.
- Empty, then rd&wr with 0xA5 -> count=1, empty=0, r_data=0xA5 next cycle, underflow=1.
- 40 cycles of random rd/wr with W=2 -> scoreboard order matches, count never exceeds 4, full/empty/almost flags match a reference count each cycle, pointer wrap exercised 5+ times.
- Flush and reset:
  - count=3 with clr and wr(0x77) asserted -> next cycle count=0, empty=1, overflow/underflow=0, 0x77 discarded.
  - rst_n pulsed low mid-burst -> outputs at reset values immediately, without waiting for a clock edge.
